hmac_sha_arbiter: RTL and testbench

HMAC_SHA_ARBITER -- requirements
Module: hmac_sha_arbiter

---
 rtl/hmac_sha_arbiter.sv | 133 +++++++++++++
 tb/tb_hmac_sha_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_sha_arbiter.sv
// Two-requester round-robin arbiter for a shared HMAC-SHA core: grants the core,
// launches one job, waits for the digest (or a timeout) and reports completion to the owner.
module hmac_sha_arbiter #(
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [159:0] req0_sha_in,
  input  logic [159:0] req1_sha_in,
  input  logic [511:0] req0_key,
  input  logic [511:0] req1_key,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic         err,
  output logic [159:0] hash_out,
  output logic [159:0] core_sha_in,
  output logic [511:0] core_key,
  output logic         core_start,
  input  logic         core_ready,
  input  logic         core_valid,
  input  logic [159:0] core_hash,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Counter value in the last WAIT cycle; the job ends TIMEOUT cycles after LAUNCH.
  localparam logic [9:0] LAST_WAIT = 10'(TIMEOUT - 2);

  state_e       state_q, state_d;
  logic [1:0]   gnt_q, gnt_d;
  logic [1:0]   done_q, done_d;
  logic         err_q, err_d;
  logic         start_q, start_d;
  logic         rr_q, rr_d;
  logic [9:0]   cnt_q, cnt_d;
  logic [159:0] hash_q, hash_d;
  logic [159:0] sha_q, sha_d;
  logic [511:0] key_q, key_d;
  logic         win;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    err_d   = err_q;
    start_d = 1'b0;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    hash_d  = hash_q;
    sha_d   = sha_q;
    key_d   = key_q;
    // With both requests set the pointer decides; otherwise req[1] names the lone requester.
    win     = (req == 2'b11) ? rr_q : req[1];

    case (state_q)
      IDLE: begin
        if (req != 2'b00 && core_ready) begin
          state_d = LAUNCH;
          gnt_d   = win ? 2'b10 : 2'b01;
          start_d = 1'b1;
          sha_d   = win ? req1_sha_in : req0_sha_in;
          key_d   = win ? req1_key : req0_key;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 10'd1;
        if (core_valid) begin
          hash_d  = core_hash;
          err_d   = 1'b0;
          done_d  = gnt_q;
          state_d = DONE;
        end else if (cnt_q == LAST_WAIT) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = 2'b00;
        rr_d    = ~gnt_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      hash_q  <= '0;
      sha_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      hash_q  <= hash_d;
      sha_q   <= sha_d;
      key_q   <= key_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign hash_out    = hash_q;
  assign core_sha_in = sha_q;
  assign core_key    = key_q;
  assign core_start  = start_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hmac_sha_arbiter.sv
// Bench for hmac_sha_arbiter: two instances (default TIMEOUT and TIMEOUT=10) share stimulus
// and are compared every cycle against a job-window model, plus directed literal checks.
module tb_hmac_sha_arbiter;

  localparam int TMO0 = 200;
  localparam int TMO1 = 10;
  localparam logic [159:0] H_A5 = 160'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
  localparam logic [159:0] H_12 = 160'h1234567890ABCDEF1234567890ABCDEF12345678;
  localparam logic [159:0] H_1  = 160'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00C0FFEE00;
  localparam logic [159:0] H_2  = 160'h0BADF00D0BADF00D0BADF00D0BADF00D0BADF00D;
  localparam logic [159:0] H_3  = 160'h5555AAAA5555AAAA5555AAAA5555AAAA5555AAAA;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   req;
  logic [159:0] sha0, sha1, core_hash;
  logic [511:0] key0, key1;
  logic         core_ready, core_valid;

  logic [1:0]   gnt_o[2], done_o[2], state_o[2];
  logic         err_o[2], start_o[2];
  logic [159:0] hash_o[2], csha_o[2];
  logic [511:0] ckey_o[2];

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  bit     cmp_en = 1'b0;

  hmac_sha_arbiter #(.TIMEOUT(TMO0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req0_sha_in(sha0), .req1_sha_in(sha1), .req0_key(key0), .req1_key(key1),
    .gnt(gnt_o[0]), .done(done_o[0]), .err(err_o[0]), .hash_out(hash_o[0]),
    .core_sha_in(csha_o[0]), .core_key(ckey_o[0]), .core_start(start_o[0]),
    .core_ready(core_ready), .core_valid(core_valid), .core_hash(core_hash),
    .dbg_state(state_o[0])
  );

  hmac_sha_arbiter #(.TIMEOUT(TMO1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req0_sha_in(sha0), .req1_sha_in(sha1), .req0_key(key0), .req1_key(key1),
    .gnt(gnt_o[1]), .done(done_o[1]), .err(err_o[1]), .hash_out(hash_o[1]),
    .core_sha_in(csha_o[1]), .core_key(ckey_o[1]), .core_start(start_o[1]),
    .core_ready(core_ready), .core_valid(core_valid), .core_hash(core_hash),
    .dbg_state(state_o[1])
  );

  // Model: a job is a window of cycles measured from its launch cycle. Digest accepted
  // at launch+1 .. launch+TIMEOUT-1; done appears one cycle later (or at launch+TIMEOUT).
  typedef struct {
    bit           busy;
    bit           fin;
    bit           rr;
    int           owner;
    longint       launch;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         err;
    logic         start;
    logic [159:0] hash;
    logic [159:0] sha;
    logic [511:0] key;
  } mdl_t;

  mdl_t m[2];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.busy = 0; r.fin = 0; r.rr = 0; r.owner = 0; r.launch = 0;
    r.gnt = '0; r.done = '0; r.err = 1'b0; r.start = 1'b0;
    r.hash = '0; r.sha = '0; r.key = '0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) m[i] = mdl_reset();
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        longint p;
        int     win;
        int     tmo;
        tmo = (i == 0) ? TMO0 : TMO1;
        m[i].start = 1'b0;
        m[i].done  = 2'b00;
        if (m[i].fin) begin
          m[i].fin  = 0;
          m[i].busy = 0;
          m[i].gnt  = 2'b00;
          m[i].rr   = (m[i].owner == 0);
        end else if (!m[i].busy) begin
          if (req != 2'b00 && core_ready) begin
            if (req == 2'b11) win = m[i].rr ? 1 : 0;
            else              win = req[1] ? 1 : 0;
            m[i].busy   = 1;
            m[i].owner  = win;
            m[i].launch = cyc;
            m[i].gnt    = (win == 1) ? 2'b10 : 2'b01;
            m[i].start  = 1'b1;
            m[i].sha    = (win == 1) ? sha1 : sha0;
            m[i].key    = (win == 1) ? key1 : key0;
          end
        end else begin
          p = cyc - 1 - m[i].launch;
          if (p >= 1 && core_valid) begin
            m[i].done = m[i].gnt;
            m[i].err  = 1'b0;
            m[i].hash = core_hash;
            m[i].fin  = 1;
          end else if (p == longint'(tmo - 1)) begin
            m[i].done = m[i].gnt;
            m[i].err  = 1'b1;
            m[i].fin  = 1;
          end
        end
      end
    end
  end

  // scoreboard
  task automatic chk(input string name, input int inst, input logic [511:0] act,
                     input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h want %0h", name, inst, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("gnt", i, gnt_o[i], m[i].gnt);
        chk("done", i, done_o[i], m[i].done);
        chk("err", i, err_o[i], m[i].err);
        chk("core_start", i, start_o[i], m[i].start);
        chk("hash_out", i, hash_o[i], m[i].hash);
        chk("core_sha_in", i, csha_o[i], m[i].sha);
        chk("core_key", i, ckey_o[i], m[i].key);
      end
    end
  end

  // drivers
  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [511:0] rnd512();
    return {rnd160(), rnd160(), rnd160(), 32'($urandom())};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_valid(input logic [159:0] h);
    core_valid = 1'b1;
    core_hash  = h;
    tick();
    core_valid = 1'b0;
  endtask

  task automatic wait_start(input int i, input int lim, output bit seen);
    seen = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (start_o[i]) begin seen = 1; break; end
    end
  endtask

  task automatic wait_done(input int i, input int lim, output bit seen);
    seen = 0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (done_o[i] != 2'b00) begin seen = 1; break; end
    end
  endtask

  task automatic wait_idle(input int lim);
    bit seen;
    seen = 0;
    req = 2'b00;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (gnt_o[0] == 2'b00 && gnt_o[1] == 2'b00) begin seen = 1; break; end
    end
    chk("idle_reached", 0, seen, 1);
  endtask

  initial begin
    bit     seen;
    longint st;
    int     d;
    logic [1:0] exp_g;

    rst_n = 1'b0; req = 2'b00; core_ready = 1'b0; core_valid = 1'b0; core_hash = '0;
    sha0 = '0; sha1 = '0; key0 = '0; key1 = '0;
    @(posedge clk);
    #1 cmp_en = 1'b1;

    // reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_gnt", i, gnt_o[i], 0);
      chk("rst_done", i, done_o[i], 0);
      chk("rst_start", i, start_o[i], 0);
      chk("rst_hash", i, hash_o[i], 0);
      chk("rst_key", i, ckey_o[i], 0);
    end
    tick();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // single job, digest 80 cycles after launch
    tick();
    sha0 = H_12; key0 = rnd512(); sha1 = rnd160(); key1 = rnd512();
    req = 2'b01; core_ready = 1'b1;
    wait_start(0, 20, seen);
    chk("single_start_seen", 0, seen, 1);
    chk("single_gnt", 0, gnt_o[0], 2'b01);
    chk("single_sha", 0, csha_o[0], H_12);
    st = cyc;
    repeat (80) tick();
    pulse_valid(H_A5);
    wait_done(0, 20, seen);
    chk("single_done_seen", 0, seen, 1);
    chk("single_latency", 0, 512'(cyc - st), 81);
    chk("single_done", 0, done_o[0], 2'b01);
    chk("single_err", 0, err_o[0], 0);
    chk("single_hash", 0, hash_o[0], H_A5);
    wait_idle(400);

    // known digest, then timeout on the short-timeout instance
    req = 2'b10;
    wait_start(1, 20, seen);
    chk("pre_start_seen", 1, seen, 1);
    repeat (4) tick();
    pulse_valid(H_1);
    wait_done(1, 20, seen);
    chk("pre_done_seen", 1, seen, 1);
    wait_idle(400);
    req = 2'b10;
    wait_start(1, 20, seen);
    chk("tmo_start_seen", 1, seen, 1);
    st = cyc;
    wait_done(1, 30, seen);
    chk("tmo_done_seen", 1, seen, 1);
    chk("tmo_latency", 1, 512'(cyc - st), 10);
    chk("tmo_done", 1, done_o[1], 2'b10);
    chk("tmo_err", 1, err_o[1], 1);
    chk("tmo_hash_kept", 1, hash_o[1], H_1);
    req = 2'b11;
    wait_start(1, 20, seen);
    chk("rr_start_seen", 1, seen, 1);
    chk("rr_flipped_gnt", 1, gnt_o[1], 2'b01);
    wait_idle(400);

    // digest coinciding with the timeout cycle wins
    req = 2'b10;
    wait_start(1, 20, seen);
    chk("edge_start_seen", 1, seen, 1);
    st = cyc;
    repeat (9) tick();
    pulse_valid(H_2);
    wait_done(1, 20, seen);
    chk("edge_done_seen", 1, seen, 1);
    chk("edge_latency", 1, 512'(cyc - st), 10);
    chk("edge_err", 1, err_o[1], 0);
    chk("edge_hash", 1, hash_o[1], H_2);
    wait_idle(400);

    // digest pulse while idle is ignored
    pulse_valid(H_3);
    repeat (2) @(negedge clk);
    chk("idle_valid_hash", 0, hash_o[0], H_2);
    chk("idle_valid_hash", 1, hash_o[1], H_2);

    // core busy for 20 cycles
    req = 2'b10; core_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      chk("busy_gnt", 0, gnt_o[0], 0);
      chk("busy_start", 0, start_o[0], 0);
    end
    core_ready = 1'b1;
    @(negedge clk);
    chk("ready_gnt", 0, gnt_o[0], 2'b10);
    chk("ready_gnt", 1, gnt_o[1], 2'b10);

    // reset in the middle of a job
    repeat (5) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_gnt", i, gnt_o[i], 0);
      chk("async_done", i, done_o[i], 0);
      chk("async_start", i, start_o[i], 0);
      chk("async_hash", i, hash_o[i], 0);
      chk("async_sha", i, csha_o[i], 0);
    end
    repeat (3) tick();
    req = 2'b11; sha0 = rnd160(); sha1 = rnd160(); key0 = rnd512(); key1 = rnd512();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // contention: grants alternate starting with requester 0
    for (int j = 0; j < 4; j++) begin
      wait_start(0, 50, seen);
      chk("cont_start_seen", j, seen, 1);
      exp_g = (j % 2 == 1) ? 2'b10 : 2'b01;
      chk("cont_gnt0", j, gnt_o[0], exp_g);
      chk("cont_gnt1", j, gnt_o[1], exp_g);
      chk("cont_sha", j, csha_o[0], (j % 2 == 1) ? sha1 : sha0);
      chk("cont_key", j, ckey_o[0], (j % 2 == 1) ? key1 : key0);
      d = $urandom_range(3, 8);
      repeat (d) tick();
      pulse_valid(rnd160());
    end
    wait_idle(400);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      tick();
      req        = 2'($urandom_range(0, 3));
      core_ready = ($urandom_range(0, 3) != 0);
      core_valid = ($urandom_range(0, 5) == 0);
      core_hash  = rnd160();
      if ($urandom_range(0, 15) == 0) begin sha0 = rnd160(); key0 = rnd512(); end
      if ($urandom_range(0, 15) == 0) begin sha1 = rnd160(); key1 = rnd512(); end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    req = 2'b00; core_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
